sysbus_arbiter: RTL and testbench
=================================

Name: sysbus_arbiter

Overview:
Parametrised N-channel front end that places several requesters (instruction fetch, data load/store, later a prefetcher) onto the single Sysbus request/response pair of the core top level. It replaces the direct fetch-to-bus hookup: it grants one channel at a time round-robin, issues the address, sends write data beats, and routes read response beats back to the owning channel. One transaction is outstanding at a time.

Parameters:
BUS_DATA_WIDTH, 64, width of bus_req/bus_resp and of each channel address and data word
BUS_TAG_WIDTH, 13, width of bus_reqtag/bus_resptag
NUM_CH, 2, number of requester channels (1..8); channel 0 = fetch
RESP_BEATS, 8, data beats per read response (power of two, 1..16)
WR_BEATS, 8, data beats following a write address (1..16)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
ch_req_valid  in  NUM_CH  per-channel request pending
ch_req_we  in  NUM_CH  1 = write, 0 = read
ch_req_addr  in  NUM_CH*BUS_DATA_WIDTH  flattened request addresses
ch_req_tag  in  NUM_CH*BUS_TAG_WIDTH  flattened tags, passed to bus unchanged
ch_req_ready  out  NUM_CH  one-cycle pulse: address accepted by bus
ch_wdata  in  NUM_CH*BUS_DATA_WIDTH  flattened write data, current beat
ch_wdata_ready  out  NUM_CH  one-cycle pulse: current write beat consumed
ch_resp_valid  out  NUM_CH  read beat valid for that channel
ch_resp_data  out  BUS_DATA_WIDTH  read beat data (shared, qualified by ch_resp_valid)
ch_resp_last  out  1  asserted with final beat
bus_reqcyc  out  1  Sysbus request cycle
bus_req  out  BUS_DATA_WIDTH  address or write-data beat
bus_reqtag  out  BUS_TAG_WIDTH  tag of granted request
bus_reqack  in  1  bus accepted current request beat
bus_respcyc  in  1  response beat present
bus_resp  in  BUS_DATA_WIDTH  response data
bus_resptag  in  BUS_TAG_WIDTH  response tag
bus_respack  out  1  response beat consumed

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = 0; beat counter = 0. Reset asserted mid-transaction aborts it immediately. No response is delivered to the channel, and stale bus beats after reset deassertion are acked and dropped until IDLE sees a new grant.
- States: IDLE, ADDR, WDATA, RESP.
- IDLE: if any ch_req_valid, grant the lowest-index requester at or after the pointer (wrap at NUM_CH). Latch index, we, addr, tag. Go to ADDR the next cycle. No grant is issued in the cycle reset deasserts.
- ADDR: bus_reqcyc=1, bus_req=addr, bus_reqtag=tag, held stable until bus_reqack. On ack: pulse ch_req_ready[g]; pointer = g+1 mod NUM_CH. Go to WDATA if we, else RESP.
- WDATA: bus_reqcyc=1, bus_req=ch_wdata[g]. Each bus_reqack pulses ch_wdata_ready[g] and increments the counter. After WR_BEATS acks, clear the counter and go to IDLE. Writes have no response phase.
- RESP: bus_respack = bus_respcyc && (bus_resptag == latched tag), combinational. Each matching beat: ch_resp_valid[g]=1, ch_resp_data=bus_resp, same cycle, zero latency. A beat whose tag does not match is not acked and not forwarded. On beat RESP_BEATS-1: ch_resp_last=1, clear the counter, go to IDLE. A new grant can occur in the following cycle.
- Channel must hold valid/addr/tag stable until ch_req_ready. Dropping valid before ready is illegal (assertion).
- Simultaneous bus_reqack and bus_respcyc cannot occur in the same state. A respcyc outside RESP is not acked.
- Counter width: $clog2(max(RESP_BEATS, WR_BEATS))+1; no wrap beyond the terminal count.
- NUM_CH=1: pointer is constant 0; behaviour otherwise identical.

Decomposition:
- Package sysbus_arb_pkg: state enum (IDLE/ADDR/WDATA/RESP), function for NUM_CH-wide round-robin pick, localparam for counter width.
- One sub-module: rr_picker (combinational request vector plus pointer to one-hot grant and index). The FSM, latches and counter stay in sysbus_arbiter.

Test Plan:
- Single read, ch0, addr 0x1000, tag 0x1100; bus acks after 3 cycles, then sends 8 beats 0xA0..0xA7 with matching tag -> ch_req_ready[0] one pulse; 8 ch_resp_valid[0] beats with data A0..A7 in order; last on A7; bus_respack high 8 cycles.
- ch0 and ch1 both valid from reset release, reads -> ch0 served first, then ch1. With both re-requesting, grants alternate 0,1,0,1 over four transactions.
- Write, ch1, WR_BEATS=8, bus_reqack toggling every other cycle -> bus_req carries the address, then 8 data beats. ch_wdata_ready[1] pulses exactly 8 times. No bus_respack; back to IDLE.
- Read pending with an interleaved respcyc beat of tag 0x0777 -> that beat not acked, not forwarded. Matching beats are still delivered, 8 total.
- Reset asserted asynchronously during beat 4 of a read -> all outputs 0 within the same cycle. After release, a new ch1 request is granted and completes normally.
- NUM_CH=4, RESP_BEATS=1: requests on ch2 and ch3 only -> grant order 2,3. A single beat per read carries ch_resp_last.

Source files
------------

// File: rtl/sysbus_arbiter_pkg.sv
// Shared types and helpers for the Sysbus request arbiter.
package sysbus_arb_pkg;

    localparam int MAX_CH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // Beat counter must reach the larger terminal count without wrapping.
    function automatic int cnt_width(input int resp_beats, input int wr_beats);
        int m;
        m = (resp_beats > wr_beats) ? resp_beats : wr_beats;
        return $clog2(m) + 1;
    endfunction

    function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int                num_ch);
        rr_pick_t p;
        int       j;
        p = '0;
        for (int k = 0; k < MAX_CH; k++) begin
            if (k < num_ch) begin
                j = int'(ptr) + k;
                if (j >= num_ch) j = j - num_ch;
                if (!p.found && req[j[2:0]]) begin
                    p.found = 1'b1;
                    p.idx   = j[2:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/sysbus_arbiter_if.sv
// Channel-side and Sysbus-side signals of the arbiter, flattened per channel.
interface sysbus_arbiter_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int NUM_CH         = 2
);
    logic [NUM_CH-1:0]                ch_req_valid;
    logic [NUM_CH-1:0]                ch_req_we;
    logic [NUM_CH*BUS_DATA_WIDTH-1:0] ch_req_addr;
    logic [NUM_CH*BUS_TAG_WIDTH-1:0]  ch_req_tag;
    logic [NUM_CH-1:0]                ch_req_ready;
    logic [NUM_CH*BUS_DATA_WIDTH-1:0] ch_wdata;
    logic [NUM_CH-1:0]                ch_wdata_ready;
    logic [NUM_CH-1:0]                ch_resp_valid;
    logic [BUS_DATA_WIDTH-1:0]        ch_resp_data;
    logic                             ch_resp_last;
    logic                             bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0]        bus_req;
    logic [BUS_TAG_WIDTH-1:0]         bus_reqtag;
    logic                             bus_reqack;
    logic                             bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0]        bus_resp;
    logic [BUS_TAG_WIDTH-1:0]         bus_resptag;
    logic                             bus_respack;

    modport master (
        input  ch_req_valid, ch_req_we, ch_req_addr, ch_req_tag, ch_wdata,
               bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        output ch_req_ready, ch_wdata_ready, ch_resp_valid, ch_resp_data,
               ch_resp_last, bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );

    modport slave (
        output ch_req_valid, ch_req_we, ch_req_addr, ch_req_tag, ch_wdata,
               bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        input  ch_req_ready, ch_wdata_ready, ch_resp_valid, ch_resp_data,
               ch_resp_last, bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );
endinterface

// File: rtl/sysbus_arbiter_rr_picker.sv
// Round-robin pick: lowest-index requester at or after the pointer, wrapping.
module rr_picker
    import sysbus_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IW     = 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IW-1:0]     i_ptr,
    output logic              o_any,
    output logic [IW-1:0]     o_idx,
    output logic [NUM_CH-1:0] o_grant
);
    rr_pick_t w_pick;

    always_comb begin
        w_pick  = rr_pick(MAX_CH'(i_req), 3'(i_ptr), NUM_CH);
        o_any   = w_pick.found;
        o_idx   = IW'(w_pick.idx);
        o_grant = w_pick.found ? (NUM_CH'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/sysbus_arbiter.sv
// N-channel round-robin front end onto the single Sysbus request/response pair.
// One transaction outstanding; reads route tagged beats back to the owner.
module sysbus_arbiter
    import sysbus_arb_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int NUM_CH         = 2,
    parameter int RESP_BEATS     = 8,
    parameter int WR_BEATS       = 8
) (
    input  logic             clk,
    input  logic             reset,
    sysbus_arbiter_if.master bus
);
    localparam int IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = cnt_width(RESP_BEATS, WR_BEATS);

    arb_state_t                r_state;
    logic [IW-1:0]             r_ptr;
    logic [IW-1:0]             r_gidx;
    logic                      r_we;
    logic [BUS_DATA_WIDTH-1:0] r_addr;
    logic [BUS_TAG_WIDTH-1:0]  r_tag;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_arm;
    logic                      r_flush;

    logic                      w_any;
    logic [IW-1:0]             w_idx;
    logic [NUM_CH-1:0]         w_grant;
    logic [NUM_CH-1:0]         w_owner;
    logic [IW-1:0]             w_ptr_next;
    logic                      w_addr_ack;
    logic                      w_wr_ack;
    logic                      w_wr_done;
    logic                      w_resp_match;
    logic                      w_resp_done;
    logic                      w_stale;

    rr_picker #(.NUM_CH(NUM_CH), .IW(IW)) u_picker (
        .i_req   (bus.ch_req_valid),
        .i_ptr   (r_ptr),
        .o_any   (w_any),
        .o_idx   (w_idx),
        .o_grant (w_grant)
    );

    always_comb begin
        w_owner      = NUM_CH'(1) << r_gidx;
        w_ptr_next   = (r_gidx == IW'(NUM_CH - 1)) ? '0 : r_gidx + 1'b1;
        w_addr_ack   = (r_state == ADDR)  && bus.bus_reqack;
        w_wr_ack     = (r_state == WDATA) && bus.bus_reqack;
        w_wr_done    = w_wr_ack && (r_cnt == CNT_W'(WR_BEATS - 1));
        w_resp_match = (r_state == RESP) && bus.bus_respcyc && (bus.bus_resptag == r_tag);
        w_resp_done  = w_resp_match && (r_cnt == CNT_W'(RESP_BEATS - 1));
        // Beats left over from a transaction aborted by reset are swallowed until the next grant.
        w_stale      = (r_state == IDLE) && r_flush && bus.bus_respcyc && !reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_tag   <= '0;
            r_cnt   <= '0;
            r_arm   <= 1'b0;
            r_flush <= 1'b1;
        end else begin
            r_arm <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (r_arm && w_any) begin
                        r_gidx  <= w_idx;
                        r_we    <= |(bus.ch_req_we & w_grant);
                        r_addr  <= bus.ch_req_addr[w_idx*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                        r_tag   <= bus.ch_req_tag[w_idx*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
                        r_flush <= 1'b0;
                        r_state <= ADDR;
                    end
                end
                ADDR: begin
                    if (w_addr_ack) begin
                        r_ptr   <= w_ptr_next;
                        r_state <= r_we ? WDATA : RESP;
                    end
                end
                WDATA: begin
                    if (w_wr_done) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else if (w_wr_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (w_resp_done) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else if (w_resp_match) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ch_req_ready   = w_addr_ack ? w_owner : '0;
        bus.ch_wdata_ready = w_wr_ack ? w_owner : '0;
        bus.ch_resp_valid  = w_resp_match ? w_owner : '0;
        bus.ch_resp_data   = w_resp_match ? bus.bus_resp : '0;
        bus.ch_resp_last   = w_resp_done;
        bus.bus_reqcyc     = (r_state == ADDR) || (r_state == WDATA);
        bus.bus_reqtag     = bus.bus_reqcyc ? r_tag : '0;
        bus.bus_respack    = w_resp_match || w_stale;
        if (r_state == ADDR)
            bus.bus_req = r_addr;
        else if (r_state == WDATA)
            bus.bus_req = bus.ch_wdata[r_gidx*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        else
            bus.bus_req = '0;
    end

    // A requester may not withdraw while its address is on the bus.
    a_hold_valid: assert property (@(posedge clk) disable iff (reset)
        (r_state == ADDR) |-> bus.ch_req_valid[r_gidx]);

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Scoreboard bench: stimulus pushes expected channel events, negedge monitors pop and compare.
module tb_sysbus_arbiter;

    typedef struct {
        int          kind;   // 0 = addr accepted, 1 = write beat, 2 = read beat
        int          ch;
        logic [63:0] data;
        logic [12:0] tag;
        logic        last;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sysbus_arbiter_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .NUM_CH(2)) ifa ();
    sysbus_arbiter_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .NUM_CH(4)) ifb ();

    sysbus_arbiter #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .NUM_CH(2),
                     .RESP_BEATS(8), .WR_BEATS(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    sysbus_arbiter #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .NUM_CH(4),
                     .RESP_BEATS(1), .WR_BEATS(8)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    ev_t qa[$];
    ev_t qb[$];
    int  checks = 0;
    int  errors = 0;
    bit  inv_en = 1'b1;
    int  ack_cnt_a = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ev_t mk_ev(input int kind, input int ch, input logic [63:0] data,
                                  input logic [12:0] tag, input logic last);
        ev_t e;
        e.kind = kind; e.ch = ch; e.data = data; e.tag = tag; e.last = last;
        return e;
    endfunction

    task automatic cmp_ev(input string who, input ev_t e, input int kind, input logic [7:0] vec,
                          input logic [63:0] data, input logic [12:0] tag, input logic last);
        logic [7:0] onehot;
        onehot = 8'd1 << e.ch;
        check({who, "_kind"}, 64'(kind), 64'(e.kind));
        check({who, "_chan"}, 64'(vec), 64'(onehot));
        check({who, "_data"}, data, e.data);
        if (kind != 2) check({who, "_tag"}, 64'(tag), 64'(e.tag));
        else           check({who, "_last"}, 64'(last), 64'(e.last));
    endtask

    task automatic unexpected(input string who);
        checks++;
        errors++;
        $display("FAIL %s_unexpected: got a channel event, expected none (queue empty)", who);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ifa.bus_respack) ack_cnt_a++;
            if (inv_en && ifa.bus_respcyc)
                check("a_respack_vs_fwd", 64'(ifa.bus_respack), 64'(|ifa.ch_resp_valid));
            if (|ifa.ch_req_ready) begin
                if (qa.size() == 0) unexpected("a_req");
                else cmp_ev("a_req", qa.pop_front(), 0, 8'(ifa.ch_req_ready), ifa.bus_req, ifa.bus_reqtag, 1'b0);
            end
            if (|ifa.ch_wdata_ready) begin
                if (qa.size() == 0) unexpected("a_wbeat");
                else cmp_ev("a_wbeat", qa.pop_front(), 1, 8'(ifa.ch_wdata_ready), ifa.bus_req, ifa.bus_reqtag, 1'b0);
            end
            if (|ifa.ch_resp_valid) begin
                if (qa.size() == 0) unexpected("a_rbeat");
                else cmp_ev("a_rbeat", qa.pop_front(), 2, 8'(ifa.ch_resp_valid), ifa.ch_resp_data, 13'd0, ifa.ch_resp_last);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (ifb.bus_respcyc)
                check("b_respack_vs_fwd", 64'(ifb.bus_respack), 64'(|ifb.ch_resp_valid));
            if (|ifb.ch_req_ready) begin
                if (qb.size() == 0) unexpected("b_req");
                else cmp_ev("b_req", qb.pop_front(), 0, 8'(ifb.ch_req_ready), ifb.bus_req, ifb.bus_reqtag, 1'b0);
            end
            if (|ifb.ch_resp_valid) begin
                if (qb.size() == 0) unexpected("b_rbeat");
                else cmp_ev("b_rbeat", qb.pop_front(), 2, 8'(ifb.ch_resp_valid), ifb.ch_resp_data, 13'd0, ifb.ch_resp_last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_reqcyc(input bit on_b, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if ((on_b ? ifb.bus_reqcyc : ifa.bus_reqcyc) == 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reqcyc_timeout: got no bus_reqcyc, expected one within 40 cycles");
        end
    endtask

    task automatic set_ch_a(input int ch, input logic we, input logic [63:0] addr, input logic [12:0] tag);
        ifa.ch_req_we[ch]             = we;
        ifa.ch_req_addr[ch*64 +: 64]  = addr;
        ifa.ch_req_tag[ch*13 +: 13]   = tag;
        ifa.ch_req_valid[ch]          = 1'b1;
    endtask

    task automatic serve_read_a(input int ch, input logic [63:0] addr, input logic [12:0] tag,
                                input logic [63:0] base, input int delay, input bit bad, input bit keep);
        bit ok;
        wait_reqcyc(1'b0, ok);
        if (!ok) return;
        qa.push_back(mk_ev(0, ch, addr, tag, 1'b0));
        for (int i = 0; i < 8; i++) qa.push_back(mk_ev(2, ch, base + 64'(i), tag, i == 7));
        repeat (delay) tick();
        ifa.bus_reqack = 1'b1;
        tick();
        ifa.bus_reqack = 1'b0;
        if (!keep) ifa.ch_req_valid[ch] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bad && i == 3) begin
                ifa.bus_respcyc = 1'b1;
                ifa.bus_resptag = 13'h0777;
                ifa.bus_resp    = 64'hDEAD;
                tick();
            end
            ifa.bus_respcyc = 1'b1;
            ifa.bus_resptag = tag;
            ifa.bus_resp    = base + 64'(i);
            tick();
        end
        ifa.bus_respcyc = 1'b0;
    endtask

    task automatic serve_write_a(input int ch, input logic [63:0] addr, input logic [12:0] tag,
                                 input logic [63:0] wbase);
        bit ok;
        ifa.ch_wdata[ch*64 +: 64] = wbase;
        set_ch_a(ch, 1'b1, addr, tag);
        wait_reqcyc(1'b0, ok);
        if (!ok) return;
        qa.push_back(mk_ev(0, ch, addr, tag, 1'b0));
        for (int i = 0; i < 8; i++) qa.push_back(mk_ev(1, ch, wbase + 64'(i), tag, 1'b0));
        ifa.bus_reqack = 1'b0;
        tick();
        ifa.bus_reqack = 1'b1;
        tick();
        ifa.ch_req_valid[ch] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ifa.ch_wdata[ch*64 +: 64] = wbase + 64'(i);
            ifa.bus_reqack = 1'b0;
            tick();
            ifa.bus_reqack = 1'b1;
            tick();
        end
        ifa.bus_reqack = 1'b0;
        ifa.ch_req_we[ch] = 1'b0;
    endtask

    task automatic serve_read_b(input int ch, input logic [63:0] addr, input logic [12:0] tag,
                                input logic [63:0] data);
        bit ok;
        wait_reqcyc(1'b1, ok);
        if (!ok) return;
        qb.push_back(mk_ev(0, ch, addr, tag, 1'b0));
        qb.push_back(mk_ev(2, ch, data, tag, 1'b1));
        ifb.bus_reqack = 1'b1;
        tick();
        ifb.bus_reqack = 1'b0;
        ifb.ch_req_valid[ch] = 1'b0;
        ifb.bus_respcyc = 1'b1;
        ifb.bus_resptag = tag;
        ifb.bus_resp    = data;
        tick();
        ifb.bus_respcyc = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish within 200us");
        $fatal(1, "bench timeout");
    end

    initial begin
        ifa.ch_req_valid = '0; ifa.ch_req_we = '0; ifa.ch_req_addr = '0; ifa.ch_req_tag = '0;
        ifa.ch_wdata = '0; ifa.bus_reqack = 1'b0; ifa.bus_respcyc = 1'b0;
        ifa.bus_resp = '0; ifa.bus_resptag = '0;
        ifb.ch_req_valid = '0; ifb.ch_req_we = '0; ifb.ch_req_addr = '0; ifb.ch_req_tag = '0;
        ifb.ch_wdata = '0; ifb.bus_reqack = 1'b0; ifb.bus_respcyc = 1'b0;
        ifb.bus_resp = '0; ifb.bus_resptag = '0;

        repeat (3) tick();
        check("rst_reqcyc", 64'(ifa.bus_reqcyc), 64'd0);
        check("rst_req", ifa.bus_req, 64'd0);
        check("rst_respack", 64'(ifa.bus_respack), 64'd0);
        check("rst_req_ready", 64'(ifa.ch_req_ready), 64'd0);
        check("rst_resp_valid", 64'(ifa.ch_resp_valid), 64'd0);
        reset = 1'b0;
        tick();

        // single read on ch0
        set_ch_a(0, 1'b0, 64'h1000, 13'h1100);
        ack_cnt_a = 0;
        serve_read_a(0, 64'h1000, 13'h1100, 64'hA0, 3, 1'b0, 1'b0);
        check("t1_respack_cycles", 64'(ack_cnt_a), 64'd8);

        // both channels from reset release, alternating grants
        reset = 1'b1;
        set_ch_a(0, 1'b0, 64'h2000, 13'h0200);
        set_ch_a(1, 1'b0, 64'h3000, 13'h0301);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("no_grant_at_release", 64'(ifa.bus_reqcyc), 64'd0);
        serve_read_a(0, 64'h2000, 13'h0200, 64'hB0, 1, 1'b0, 1'b1);
        serve_read_a(1, 64'h3000, 13'h0301, 64'hC0, 0, 1'b0, 1'b1);
        serve_read_a(0, 64'h2000, 13'h0200, 64'hD0, 2, 1'b0, 1'b0);
        serve_read_a(1, 64'h3000, 13'h0301, 64'hE0, 0, 1'b0, 1'b0);

        // write on ch1 with toggling ack
        ack_cnt_a = 0;
        serve_write_a(1, 64'h4000, 13'h0042, 64'hD0);
        check("wr_back_idle", 64'(ifa.bus_reqcyc), 64'd0);
        check("wr_no_respack", 64'(ack_cnt_a), 64'd0);

        // read with a foreign-tag beat interleaved
        set_ch_a(0, 1'b0, 64'h5000, 13'h0555);
        serve_read_a(0, 64'h5000, 13'h0555, 64'hF0, 1, 1'b1, 1'b0);

        // reset during beat 4 of a read
        begin
            bit ok;
            set_ch_a(0, 1'b0, 64'h6000, 13'h0666);
            wait_reqcyc(1'b0, ok);
            qa.push_back(mk_ev(0, 0, 64'h6000, 13'h0666, 1'b0));
            for (int i = 0; i < 4; i++) qa.push_back(mk_ev(2, 0, 64'h60 + 64'(i), 13'h0666, 1'b0));
            ifa.bus_reqack = 1'b1;
            tick();
            ifa.bus_reqack = 1'b0;
            ifa.ch_req_valid[0] = 1'b0;
            for (int i = 0; i < 5; i++) begin
                ifa.bus_respcyc = 1'b1;
                ifa.bus_resptag = 13'h0666;
                ifa.bus_resp    = 64'h60 + 64'(i);
                if (i < 4) tick();
            end
            #2 reset = 1'b1;
            #1;
            check("arst_resp_valid", 64'(ifa.ch_resp_valid), 64'd0);
            check("arst_resp_data", ifa.ch_resp_data, 64'd0);
            check("arst_resp_last", 64'(ifa.ch_resp_last), 64'd0);
            check("arst_respack", 64'(ifa.bus_respack), 64'd0);
            check("arst_reqcyc", 64'(ifa.bus_reqcyc), 64'd0);
            check("arst_req", ifa.bus_req, 64'd0);
            check("arst_reqtag", 64'(ifa.bus_reqtag), 64'd0);
            ifa.bus_respcyc = 1'b0;
            check("arst_queue_drained", 64'(qa.size()), 64'd0);
            tick();
            tick();
            reset = 1'b0;
            inv_en = 1'b0;
            ifa.bus_respcyc = 1'b1;
            ifa.bus_resptag = 13'h0666;
            ifa.bus_resp    = 64'h64;
            #1;
            check("stale_acked", 64'(ifa.bus_respack), 64'd1);
            check("stale_not_fwd", 64'(ifa.ch_resp_valid), 64'd0);
            tick();
            ifa.bus_respcyc = 1'b0;
            inv_en = 1'b1;
            set_ch_a(1, 1'b0, 64'h7000, 13'h0171);
            serve_read_a(1, 64'h7000, 13'h0171, 64'h50, 2, 1'b0, 1'b0);
        end

        // four channels, single-beat reads on ch2 and ch3
        ifb.ch_req_addr[2*64 +: 64] = 64'h8000;
        ifb.ch_req_tag[2*13 +: 13]  = 13'h0022;
        ifb.ch_req_addr[3*64 +: 64] = 64'h9000;
        ifb.ch_req_tag[3*13 +: 13]  = 13'h0033;
        ifb.ch_req_valid = 4'b1100;
        serve_read_b(2, 64'h8000, 13'h0022, 64'h1234);
        serve_read_b(3, 64'h9000, 13'h0033, 64'h5678);

        tick();
        tick();
        check("a_queue_empty", 64'(qa.size()), 64'd0);
        check("b_queue_empty", 64'(qb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
